// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, then
// shifts one command byte plus odd parity and stop out on device clock edges
// and reports the device ACK (done) or its absence / a timeout (error).
// Both pads are open-drain; this block only produces the pull-low enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] io_ctrl_data,
  input  logic       io_ctrl_start,
  output logic       io_ctrl_busy,
  output logic       io_ctrl_done,
  output logic       io_ctrl_error,
  input  logic       io_keyboard_kb_clk,
  input  logic       io_keyboard_kb_data,
  output logic       io_keyboard_kb_clk_oe,
  output logic       io_keyboard_kb_data_oe
);

  // Phase counter covers the inhibit and start-bit intervals; the timeout
  // counter spans SHIFT and ACK together so it measures from clock release.
  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] ST_LAST  = PH_W'(START_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_e;

  // Odd parity: set when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bits sent after the start bit, index 0 first: data LSB first, parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d};
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            kbc_meta_q, kbc_sync_q, kbc_prev_q;
  logic            kbd_meta_q, kbd_sync_q;

  logic            fall_s;
  logic [9:0]      frame_s;

  assign fall_s  = kbc_prev_q & ~kbc_sync_q;
  assign frame_s = build_frame(data_q);

  // Two-flop synchronizers for both pads plus the previous synced clock for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      kbc_meta_q <= 1'b1;
      kbc_sync_q <= 1'b1;
      kbc_prev_q <= 1'b1;
      kbd_meta_q <= 1'b1;
      kbd_sync_q <= 1'b1;
    end else begin
      kbc_meta_q <= io_keyboard_kb_clk;
      kbc_sync_q <= kbc_meta_q;
      kbc_prev_q <= kbc_sync_q;
      kbd_meta_q <= io_keyboard_kb_data;
      kbd_sync_q <= kbd_meta_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= 8'h00;
      ph_cnt_q  <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= 4'd0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      ph_cnt_q  <= ph_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ph_cnt_d  = ph_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (io_ctrl_start) begin
          state_d  = S_INHIBIT;
          data_d   = io_ctrl_data;
          ph_cnt_d = '0;
          clk_oe_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end

      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (ph_cnt_q == INH_LAST) begin
          state_d   = S_START;
          ph_cnt_d  = '0;
          data_oe_d = 1'b1;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end

      S_START: begin
        data_oe_d = 1'b1;
        if (ph_cnt_q == ST_LAST) begin
          // Release the clock while the start bit stays driven low.
          state_d   = S_SHIFT;
          ph_cnt_d  = '0;
          to_cnt_d  = '0;
          bit_cnt_d = 4'd0;
          clk_oe_d  = 1'b0;
        end else begin
          clk_oe_d = 1'b1;
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        data_oe_d = data_oe_q;
        if (to_cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          ph_cnt_d  = '0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          busy_d    = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (fall_s) begin
            // Each falling edge presents the next frame bit; the tenth
            // (stop = 1) releases the data line.
            data_oe_d = ~frame_s[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) begin
              state_d  = S_ACK;
              ph_cnt_d = '0;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
      end

      S_ACK: begin
        if (to_cnt_q == TO_LAST) begin
          state_d  = S_IDLE;
          ph_cnt_d = '0;
          error_d  = 1'b1;
          busy_d   = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (fall_s) begin
            // Device ACK is data held low across the eleventh clock.
            state_d  = S_WAIT_IDLE;
            ph_cnt_d = '0;
            if (kbd_sync_q == 1'b0) begin
              done_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            state_d = S_ACK;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (kbc_sync_q && kbd_sync_q) begin
          state_d  = S_IDLE;
          ph_cnt_d = '0;
          busy_d   = 1'b0;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign io_ctrl_busy           = busy_q;
  assign io_ctrl_done           = done_q;
  assign io_ctrl_error          = error_q;
  assign io_keyboard_kb_clk_oe  = clk_oe_q;
  assign io_keyboard_kb_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model on open-drain lines.
// Expected frames and outcomes are queued at start time and consumed by the
// device model (frame bits) and the pulse monitor (done vs. error).
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int STC  = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 10;

  logic       clk;
  logic       rst;
  logic [7:0] io_ctrl_data;
  logic       io_ctrl_start;
  logic       io_ctrl_busy;
  logic       io_ctrl_done;
  logic       io_ctrl_error;
  logic       kb_clk_line;
  logic       kb_data_line;
  logic       kb_clk_oe;
  logic       kb_data_oe;
  logic       dev_clk_low;
  logic       dev_data_low;

  int n_cmp = 0;
  int n_bad = 0;
  int done_total = 0;
  int err_total = 0;
  logic prev_pulse = 1'b0;

  logic [10:0] frame_q[$];
  logic        out_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_CYCLES(STC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_ctrl_data(io_ctrl_data),
    .io_ctrl_start(io_ctrl_start),
    .io_ctrl_busy(io_ctrl_busy),
    .io_ctrl_done(io_ctrl_done),
    .io_ctrl_error(io_ctrl_error),
    .io_keyboard_kb_clk(kb_clk_line),
    .io_keyboard_kb_data(kb_data_line),
    .io_keyboard_kb_clk_oe(kb_clk_oe),
    .io_keyboard_kb_data_oe(kb_data_oe)
  );

  // Wired-AND of host and device pull-downs with pull-ups.
  assign kb_clk_line  = ~(kb_clk_oe | dev_clk_low);
  assign kb_data_line = ~(kb_data_oe | dev_data_low);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every done/error pulse must match the next queued outcome.
  always @(negedge clk) begin
    if (io_ctrl_done || io_ctrl_error) begin
      check("done_and_error_exclusive", {31'd0, io_ctrl_done & io_ctrl_error}, 32'd0);
      check("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
      check("pulse_was_expected", {31'd0, out_q.size() != 0}, 32'd1);
      if (out_q.size() != 0) begin
        check("outcome_done", {31'd0, io_ctrl_done}, {31'd0, out_q.pop_front()});
      end
      if (io_ctrl_done) done_total++;
      if (io_ctrl_error) err_total++;
    end
    prev_pulse = io_ctrl_done | io_ctrl_error;
  end

  // Global safety net so the run can never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_tx(input logic [7:0] d, input bit push, input bit exp_done, input bit now);
    if (!now) @(negedge clk);
    io_ctrl_data  = d;
    io_ctrl_start = 1'b1;
    if (push) begin
      frame_q.push_back({1'b1, ~^d, d, 1'b0});
      out_q.push_back(exp_done);
    end
    @(negedge clk);
    io_ctrl_start = 1'b0;
    check("busy_after_accept", {31'd0, io_ctrl_busy}, 32'd1);
  endtask

  // Device model: waits for the host to release clock with start bit low,
  // then clocks n_edges bits, sampling data on each rising clock.
  task automatic dev_run(input int n_edges, input bit do_ack, input int ack_hold, input bit chk);
    logic [10:0] got;
    logic [10:0] exp;
    int t;
    got = 11'd0;
    t = 0;
    while (!(kb_clk_line === 1'b1 && kb_data_line === 1'b0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("dev_release_seen", {31'd0, t < 500}, 32'd1);
    repeat (5) @(negedge clk);
    got[0] = kb_data_line;
    for (int k = 1; k <= n_edges && k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      got[k] = kb_data_line;
      repeat (HALF) @(negedge clk);
    end
    if (n_edges > 10) begin
      if (do_ack) dev_data_low = 1'b1;
      repeat (2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (do_ack) begin
        repeat (ack_hold) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
    if (chk) begin
      check("frame_queued", {31'd0, frame_q.size() != 0}, 32'd1);
      if (frame_q.size() != 0) begin
        exp = frame_q.pop_front();
        check("frame_bits", {21'd0, got}, {21'd0, exp});
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (io_ctrl_busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, io_ctrl_busy}, 32'd0);
    check("lines_high_at_idle", {30'd0, kb_clk_line, kb_data_line}, 32'd3);
  endtask

  initial begin
    int cnt;
    int t;
    rst           = 1'b1;
    io_ctrl_data  = 8'h00;
    io_ctrl_start = 1'b0;
    dev_clk_low   = 1'b0;
    dev_data_low  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", {31'd0, kb_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, kb_data_oe}, 32'd0);
    check("rst_busy", {31'd0, io_ctrl_busy}, 32'd0);
    check("rst_done", {31'd0, io_ctrl_done}, 32'd0);
    check("rst_error", {31'd0, io_ctrl_error}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: 0xED with ACK; clock inhibit must last INH + STC cycles.
    start_tx(8'hED, 1'b1, 1'b1, 1'b0);
    fork
      dev_run(11, 1'b1, HALF, 1'b1);
      begin
        cnt = 1;
        t = 0;
        while (t < 200) begin
          @(negedge clk);
          t++;
          if (kb_clk_oe) cnt++;
          else break;
        end
        check("t1_clk_oe_cycles", cnt, INH + STC);
      end
    join
    wait_idle("t1_busy_drop");
    check("t1_done_count", done_total, 1);

    // 2: 0x00, device does not ACK -> error.
    start_tx(8'h00, 1'b1, 1'b0, 1'b0);
    dev_run(11, 1'b0, 0, 1'b1);
    wait_idle("t2_busy_drop");
    check("t2_error_count", err_total, 1);

    // 3: 0x5A, device never clocks -> timeout error TMO cycles after release.
    start_tx(8'h5A, 1'b0, 1'b0, 1'b0);
    out_q.push_back(1'b0);
    t = 0;
    while (kb_clk_oe && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t3_release_seen", {31'd0, kb_clk_oe}, 32'd0);
    cnt = 0;
    while (!io_ctrl_error && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("t3_timeout_cycles", cnt, TMO);
    check("t3_oe_released", {30'd0, kb_clk_oe, kb_data_oe}, 32'd0);
    @(negedge clk);
    check("t3_busy_after", {31'd0, io_ctrl_busy}, 32'd0);
    check("t3_error_count", err_total, 2);
    repeat (5) @(negedge clk);

    // 4: 0xF4 with a start re-pulse carrying 0x11 mid-frame; must be ignored.
    start_tx(8'hF4, 1'b1, 1'b1, 1'b0);
    fork
      dev_run(11, 1'b1, HALF, 1'b1);
      begin
        repeat (100) @(negedge clk);
        io_ctrl_data  = 8'h11;
        io_ctrl_start = 1'b1;
        @(negedge clk);
        io_ctrl_start = 1'b0;
      end
    join
    wait_idle("t4_busy_drop");
    check("t4_done_count", done_total, 2);
    repeat (5) @(negedge clk);

    // 5: reset after four edges, then a clean 0xFF transfer.
    start_tx(8'h3C, 1'b0, 1'b0, 1'b0);
    dev_run(4, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_oe", {30'd0, kb_clk_oe, kb_data_oe}, 32'd0);
    check("t5_rst_busy", {31'd0, io_ctrl_busy}, 32'd0);
    repeat (5) @(negedge clk);
    start_tx(8'hFF, 1'b1, 1'b1, 1'b0);
    dev_run(11, 1'b1, HALF, 1'b1);
    wait_idle("t5_busy_drop");
    check("t5_done_count", done_total, 3);
    repeat (5) @(negedge clk);

    // 6: device holds data low 200 cycles after ACK; restart on busy fall.
    start_tx(8'h55, 1'b1, 1'b1, 1'b0);
    fork
      dev_run(11, 1'b1, 200, 1'b1);
      begin
        t = 0;
        while (!io_ctrl_done && t < 1000) begin
          @(negedge clk);
          t++;
        end
        check("t6_done_seen", {31'd0, io_ctrl_done}, 32'd1);
        check("t6_done_data_low", {31'd0, kb_data_line}, 32'd0);
        t = 0;
        while (io_ctrl_busy && t < 1000) begin
          @(negedge clk);
          t++;
        end
        check("t6_busy_held", {31'd0, t >= 150}, 32'd1);
        check("t6_data_high_at_drop", {31'd0, kb_data_line}, 32'd1);
        start_tx(8'hAB, 1'b1, 1'b1, 1'b1);
      end
    join
    dev_run(11, 1'b1, HALF, 1'b1);
    wait_idle("t6_busy_drop");
    check("t6_done_count", done_total, 5);

    repeat (10) @(negedge clk);
    check("final_err_count", err_total, 2);
    check("outcomes_drained", out_q.size(), 0);
    check("frames_drained", frame_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
